dso_capture_ctrl: RTL



---
 rtl/dso_capture_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dso_capture_ctrl.sv
// dso_capture_ctrl: capture controller sitting behind the trigger handshake.
// Generates the decimated sample strobe, writes samples circularly into the
// capture RAM, arms the trigger block once enough pre-trigger history is
// stored, counts post-trigger samples and reports completion.
// Optional feature macro: DSO_TRIG_ADDR_EN adds the trig_addr output
// (address of the first post-trigger sample).
`timescale 1ns/1ps

module dso_capture_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DEC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_start,
  input  logic              capture_ack,
  input  logic [DEC_W-1:0]  decimator,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              triggered,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic              wrt_smpl,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trace_end,
  output logic              busy
`ifdef DSO_TRIG_ADDR_EN
  ,
  output logic [ADDR_W-1:0] trig_addr
`endif
);

  // Decimation counter must cover the largest exponent: 2**DEC_W - 1 bits.
  localparam int CNT_W = (1 << DEC_W) - 1;
  // DEPTH expressed in the ADDR_W+1 bit arithmetic used by the sample count.
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT_TRG, SAMP, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  dec_cnt_reg;
  logic [CNT_W-1:0]  strb_mask;
  logic [DEC_W-1:0]  dec_reg;
  logic [ADDR_W-1:0] tp_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [ADDR_W-1:0] post_cnt_reg;
  logic [ADDR_W-1:0] trace_end_reg;
  logic [ADDR_W:0]   smpl_cnt_reg;
  logic              armed_reg;
  logic              set_done_reg;
  logic              cap_done_reg;
  logic              strb;
  logic              post_full;
  logic              arm_cond;
  logic              start_ok;

  // Strobe when the low 'decimator' bits of the counter are all ones.
  assign strb_mask = ~({CNT_W{1'b1}} << dec_reg);
  assign strb      = ((dec_cnt_reg & strb_mask) == strb_mask);
  assign post_full = (post_cnt_reg == tp_reg);
  // Sum cannot overflow ADDR_W+1 bits: at most (DEPTH-1) + DEPTH.
  assign arm_cond  = (({1'b0, tp_reg} + smpl_cnt_reg) >= DEPTH_C);
  assign start_ok  = (state_reg == IDLE) && capture_start;

  // Only wrt_smpl is combinational: the strobe gated by the state register.
  // The final SAMP cycle (post count reached) performs no write.
  assign wrt_smpl = strb && ((state_reg == WAIT_TRG) ||
                             ((state_reg == SAMP) && !post_full));

  assign busy             = (state_reg == WAIT_TRG) || (state_reg == SAMP);
  assign armed            = armed_reg;
  assign set_capture_done = set_done_reg;
  assign capture_done     = cap_done_reg;
  assign waddr            = waddr_reg;
  assign trace_end        = trace_end_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode; capture_start is only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (capture_start)          state_next = WAIT_TRG;
      WAIT_TRG: if (armed_reg && triggered) state_next = SAMP;
      SAMP:     if (post_full)              state_next = DONE;
      DONE:     if (capture_ack)            state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // Counters, address generation and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_reg   <= '0;
      dec_reg       <= '0;
      tp_reg        <= '0;
      waddr_reg     <= '0;
      post_cnt_reg  <= '0;
      smpl_cnt_reg  <= '0;
      trace_end_reg <= '0;
      armed_reg     <= 1'b0;
      set_done_reg  <= 1'b0;
      cap_done_reg  <= 1'b0;
    end else begin
      set_done_reg <= 1'b0;
      if (start_ok) begin
        dec_cnt_reg  <= '0;
        waddr_reg    <= '0;
        smpl_cnt_reg <= '0;
        post_cnt_reg <= '0;
        tp_reg       <= trig_pos;
        dec_reg      <= decimator;
      end
      if (busy) dec_cnt_reg <= dec_cnt_reg + 1'b1;
      if (wrt_smpl) begin
        waddr_reg <= waddr_reg + 1'b1;
        if (smpl_cnt_reg != DEPTH_C) smpl_cnt_reg <= smpl_cnt_reg + 1'b1;
        if (state_reg == SAMP) post_cnt_reg <= post_cnt_reg + 1'b1;
      end
      // Armed latches while waiting and holds through SAMP until completion.
      armed_reg <= ((state_reg == WAIT_TRG) && (armed_reg || arm_cond)) ||
                   ((state_reg == SAMP) && !post_full);
      if ((state_reg == SAMP) && post_full) begin
        set_done_reg  <= 1'b1;
        cap_done_reg  <= 1'b1;
        trace_end_reg <= waddr_reg - 1'b1;
      end
      if ((state_reg == DONE) && capture_ack) cap_done_reg <= 1'b0;
    end
  end

`ifdef DSO_TRIG_ADDR_EN
  logic [ADDR_W-1:0] trig_addr_reg;
  assign trig_addr = trig_addr_reg;

  // Capture the address the first post-trigger sample will be written to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_addr_reg <= '0;
    end else if (start_ok) begin
      trig_addr_reg <= '0;
    end else if ((state_reg == WAIT_TRG) && armed_reg && triggered) begin
      trig_addr_reg <= wrt_smpl ? (waddr_reg + 1'b1) : waddr_reg;
    end
  end
`endif

endmodule
